// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round controller:
//   - NR_DEFAULT     : default number of rounds (AES-128)
//   - fsm_t          : controller state encoding
//   - xtime          : multiply-by-x in GF(2^8) (AES polynomial 0x11b)
//   - gf_mul         : general GF(2^8) multiply, used only to build the S-box
//   - sbox           : AES forward S-box (inverse in GF(2^8) + affine map)
//   - shift_rows_src : ShiftRows byte map, out byte i <- in byte returned
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY0  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // The S-box is built from its algebraic definition rather than a table:
    // inverse = x^254 (x^2 * x^4 * ... * x^128), then the affine transform
    // s = inv ^ rotl(inv,1..4) ^ 0x63. Zero maps to zero before the affine step.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    // Bytes are numbered column-major (i = 4*col + row); row r rotates left by r.
    function automatic int shift_rows_src(input int i);
        return (i + 4 * (i % 4)) % 16;
    endfunction

endpackage

// File: rtl/aes_round.sv
// ---------------------------------------------------------------------------
// aes_round
// One combinational AES encryption round:
//   SubBytes -> ShiftRows -> MixColumns (skipped when final_round) -> AddRoundKey
// Ports:
//   state_in    [127:0] : input state, byte 0 at [127:120]
//   round_key   [127:0] : round key, same byte order
//   final_round         : 1 = omit MixColumns
//   state_out   [127:0] : resulting state
// ---------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] state_out
);

    logic [7:0] sub_b   [16];
    logic [7:0] shift_b [16];
    logic [7:0] mix_b   [16];

    genvar gi;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_sub_shift
            localparam int SRC = shift_rows_src(gi);
            assign sub_b[gi]   = sbox(state_in[127 - 8*gi -: 8]);
            assign shift_b[gi] = sub_b[SRC];
        end

        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shift_b[4*gi + 0];
            assign a1 = shift_b[4*gi + 1];
            assign a2 = shift_b[4*gi + 2];
            assign a3 = shift_b[4*gi + 3];
            // Column times the circulant matrix {02 03 01 01}; 3*a = xtime(a)^a.
            assign mix_b[4*gi + 0] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            assign mix_b[4*gi + 1] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            assign mix_b[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            assign mix_b[4*gi + 3] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end

        for (gi = 0; gi < 16; gi++) begin : g_ark
            assign state_out[127 - 8*gi -: 8] =
                (final_round ? shift_b[gi] : mix_b[gi]) ^ round_key[127 - 8*gi -: 8];
        end
    endgenerate

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES encryption controller: one round per accepted round key.
// Round keys are fetched from outside over a request/valid handshake.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : plaintext handshake, in_data [127:0]
//   rk_req/rk_idx        : round-key request and index (0..NR)
//   rk_valid/rk_data     : round key delivery, honoured only while rk_req=1
//   out_valid/out_ready  : ciphertext handshake, out_data [127:0]
//   busy                 : high whenever not IDLE
// All outputs are registered; they are computed from the next state so they
// line up with the state the FSM enters on each edge.
// ---------------------------------------------------------------------------
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic          rk_req,
    output logic [RW-1:0] rk_idx,
    input  logic          rk_valid,
    input  logic [127:0]  rk_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    fsm_t          fsm_q, fsm_d;
    logic [127:0]  st_q, st_d;
    logic [RW-1:0] round_q, round_d;
    logic          in_ready_q, in_ready_d;
    logic          rk_req_q, rk_req_d;
    logic [RW-1:0] rk_idx_q, rk_idx_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    logic [127:0]  round_out;
    logic          final_round;

    assign final_round = (round_q == LAST_ROUND);

    aes_round u_round (
        .state_in    (st_q),
        .round_key   (rk_data),
        .final_round (final_round),
        .state_out   (round_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        round_d = round_q;

        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    round_d = '0;
                    fsm_d   = KEY0;
                end
            end
            KEY0: begin
                if (rk_valid) begin
                    st_d    = st_q ^ rk_data;
                    round_d = RW'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (rk_valid) begin
                    st_d = round_out;
                    if (final_round) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q + RW'(1);
                    end
                end
            end
            DONE: begin
                // No acceptance here even if in_valid: IDLE is entered first.
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        in_ready_d  = (fsm_d == IDLE);
        rk_req_d    = (fsm_d == KEY0) || (fsm_d == ROUND);
        // KEY0 always requests key 0; outside the request states index is 0.
        rk_idx_d    = (fsm_d == ROUND) ? round_d : '0;
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            round_q     <= '0;
            in_ready_q  <= 1'b1;
            rk_req_q    <= 1'b0;
            rk_idx_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            round_q     <= round_d;
            in_ready_q  <= in_ready_d;
            rk_req_q    <= rk_req_d;
            rk_idx_q    <= rk_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rk_req    = rk_req_q;
    assign rk_idx    = rk_idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = st_q;
    assign busy      = busy_q;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of AES rounds (AES-128).
REQ-002 Parameter RW, default 4, round-counter width; SHALL satisfy 2**RW > NR.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  plaintext block offered.
REQ-006 in_ready  output  1  block accepted on the edge where in_valid && in_ready.
REQ-007 in_data  input  128  plaintext; byte 0 at [127:120], column-major per FIPS-197.
REQ-008 rk_req  output  1  round-key request.
REQ-009 rk_idx  output  RW  index of the requested round key (0..NR).
REQ-010 rk_valid  input  1  rk_data valid for rk_idx; sampled only while rk_req=1.
REQ-011 rk_data  input  128  round key, same byte order as in_data.
REQ-012 out_valid  output  1  ciphertext available.
REQ-013 out_ready  input  1  ciphertext consumed on the edge where out_valid && out_ready.
REQ-014 out_data  output  128  ciphertext.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, KEY0, ROUND and DONE.
REQ-017 IDLE: in_ready=1; on in_valid, state_reg<=in_data, round<=0, go to KEY0.
REQ-018 KEY0: rk_req=1 and rk_idx=0; on rk_valid, state_reg<=state_reg^rk_data, round<=1, go to ROUND.
REQ-019 ROUND: rk_req=1 and rk_idx=round; on rk_valid, state_reg<=aes_round(state_reg, rk_data, final=(round==NR)).
REQ-020 In ROUND with round<NR on rk_valid, round SHALL increment; with round==NR on rk_valid, the FSM SHALL go to DONE.
REQ-021 The final round SHALL apply SubBytes, ShiftRows and AddRoundKey and SHALL omit MixColumns.
REQ-022 While rk_valid=0, the FSM SHALL stall: state_reg, round, rk_req and rk_idx held unchanged.
REQ-023 DONE: out_valid=1 and out_data=state_reg; on out_ready, go to IDLE.
REQ-024 out_data SHALL be stable while out_valid && !out_ready.
REQ-025 in_ready SHALL be 0 outside IDLE; in_valid in other states SHALL be ignored.
REQ-026 rk_valid while rk_req=0 SHALL be ignored.
REQ-027 Latency with rk_valid tied high: acceptance edge N, out_valid high from edge N+NR+1; each stall cycle adds one cycle.
REQ-028 Minimum spacing between acceptances SHALL be NR+3 cycles: no accept in the DONE-exit cycle.
REQ-029 out_data SHALL be driven by state_reg in every state; its value is meaningful only while out_valid=1.
REQ-030 rk_idx SHALL equal 0 whenever rk_req=0.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, state_reg=0 and round=0.
REQ-032 Outputs under reset: in_ready=1, out_valid=0, out_data=0, rk_req=0, rk_idx=0, busy=0.
REQ-033 Reset mid-operation SHALL discard the block in flight without asserting out_valid.
REQ-034 The first edge after reset release SHALL be able to accept a block.

Structure
REQ-035 Package aes_pkg SHALL hold the NR default, the FSM state enum, the S-box function, xtime, and the ShiftRows byte map (out byte i <- in byte (i+4*(i%4))%16).
REQ-036 One combinational sub-module, aes_round (SubBytes, ShiftRows, MixColumns bypassable by final, AddRoundKey), SHALL be instantiated exactly once.
REQ-037 Key expansion SHALL NOT be part of this block; keys arrive only over the rk_* handshake.

Verification
REQ-038 FIPS-197 C.1: key 000102..0f, plaintext 00112233445566778899aabbccddeeff, rk_valid=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at acceptance+11.
REQ-039 Same vector, random 0-3 cycle rk_valid stalls per request -> same ciphertext; latency = 11 + total stalls; rk_idx sequence 0..10 exactly.
REQ-040 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable; the single handshake is followed by IDLE with in_ready=1.
REQ-041 Hold in_valid=1 with a second block throughout the first operation -> in_ready=0 until IDLE; second block accepted once and encrypted correctly.
REQ-042 Assert rst while rk_idx=5 -> all outputs at reset values next cycle, no out_valid; the subsequent C.1 run is correct.
REQ-043 Two back-to-back blocks (C.1, then all-zero plaintext with the same key) -> two correct ciphertexts, acceptances exactly 13 cycles apart with zero stalls.
